// File: rtl/aes_pkg.sv
// Shared AES widths, the GF(2^8) doubling helper and the MixColumns engine FSM states.
package aes_pkg;

    localparam int unsigned COL_W   = 32;
    localparam int unsigned STATE_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mc_state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col.sv
// Combinational forward MixColumns on a single 32-bit column; byte 0 is the MSB.
module mix_col
    import aes_pkg::*;
(
    input  logic [COL_W-1:0] i_col,
    output logic [COL_W-1:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;
    logic [7:0] w_x0, w_x1, w_x2, w_x3;

    assign {w_a0, w_a1, w_a2, w_a3} = i_col;

    assign w_x0 = xtime(w_a0);
    assign w_x1 = xtime(w_a1);
    assign w_x2 = xtime(w_a2);
    assign w_x3 = xtime(w_a3);

    // 3a is written as xtime(a) ^ a.
    assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
    assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
    assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
    assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/mix_cols_engine.sv
// Forward MixColumns engine: accepts a 128-bit state, mixes one column per clock through a
// single shared mixer, and holds the result until downstream accepts it.
module mix_cols_engine
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    mc_state_e          r_fsm;
    logic [1:0]         r_col_idx;
    logic [STATE_W-1:0] r_state;
    logic               r_ready_en;
    logic [COL_W-1:0]   w_col_in;
    logic [COL_W-1:0]   w_col_out;
    logic               w_accept;

    // Keeps in_ready low while reset is held without a combinational path from rst_n.
    assign in_ready  = r_ready_en & ((r_fsm == IDLE) | ((r_fsm == DONE) & out_ready));
    assign w_accept  = in_valid & in_ready;
    assign out_valid = (r_fsm == DONE);
    assign busy      = (r_fsm == BUSY);
    assign out_state = r_state;

    always_comb begin
        w_col_in = r_state[127:96];
        unique case (r_col_idx)
            2'd0: w_col_in = r_state[127:96];
            2'd1: w_col_in = r_state[95:64];
            2'd2: w_col_in = r_state[63:32];
            2'd3: w_col_in = r_state[31:0];
        endcase
    end

    mix_col u_mix_col (
        .i_col (w_col_in),
        .o_col (w_col_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fsm      <= IDLE;
            r_col_idx  <= 2'd0;
            r_state    <= '0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state   <= in_state;
                        r_col_idx <= 2'd0;
                        r_fsm     <= BUSY;
                    end
                end
                BUSY: begin
                    unique case (r_col_idx)
                        2'd0: r_state[127:96] <= w_col_out;
                        2'd1: r_state[95:64]  <= w_col_out;
                        2'd2: r_state[63:32]  <= w_col_out;
                        2'd3: r_state[31:0]   <= w_col_out;
                    endcase
                    r_col_idx <= r_col_idx + 2'd1;
                    if (r_col_idx == 2'd3) begin
                        r_fsm <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            r_state   <= in_state;
                            r_col_idx <= 2'd0;
                            r_fsm     <= BUSY;
                        end else begin
                            r_fsm <= IDLE;
                        end
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_cols_engine.sv
// Self-checking bench for mix_cols_engine against a generic GF(2^8) matrix-multiply model.
module tb_mix_cols_engine;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mix_cols_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix rows are {2,3,1,1} rotated right by the row number.
    function automatic logic [127:0] mix_state(input logic [127:0] s);
        logic [7:0]   base [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r;
        base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++) a[k] = s[127 - 32*c - 8*k -: 8];
            for (int row = 0; row < 4; row++) begin
                b = 8'h00;
                for (int k = 0; k < 4; k++) b = b ^ gmul(a[k], base[(k - row) & 3]);
                r[127 - 32*c - 8*row -: 8] = b;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a state, wait for in_ready, then step through the accept edge.
    task automatic send_accept(input logic [127:0] s);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_state = s;
        while (!in_ready && g < 50) begin
            tick();
            g++;
        end
        check("accept_ready", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        logic [127:0] s1, s2, exp, held;
        int lat, hold;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0;
        repeat (3) tick();
        check("rst_in_ready",  {127'b0, in_ready},  128'd0);
        check("rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("rst_busy",      {127'b0, busy},      128'd0);
        check("rst_out_state", out_state,           128'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready",  {127'b0, in_ready},  128'd1);
        check("post_rst_out_valid", {127'b0, out_valid}, 128'd0);
        check("post_rst_busy",      {127'b0, busy},      128'd0);

        // FIPS-197 vector with backpressure and a refused second request.
        send_accept(128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check("fips_busy", {127'b0, busy}, 128'd1);
        wait_done(lat);
        check("fips_latency", lat, 4);
        check("fips_out", out_state, 128'h046681e5e0cb199a48f8d37a2806264c);
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_stable",    out_state,            128'h046681e5e0cb199a48f8d37a2806264c);
            check("bp_in_ready",  {127'b0, in_ready},   128'd0);
            check("bp_out_valid", {127'b0, out_valid},  128'd1);
            check("bp_no_accept", {127'b0, busy},       128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {127'b0, in_ready}, 128'd1);
        tick();
        check("release_out_valid", {127'b0, out_valid}, 128'd0);
        check("release_idle_busy", {127'b0, busy},      128'd0);

        // Identity columns must pass through.
        s1 = 128'hc9dad76a_926bd4b6_01010101_c6c6c6c6;
        send_accept(s1);
        wait_done(lat);
        check("ident_latency", lat, 4);
        check("ident_out", out_state, mix_state(s1));
        check("ident_cols", out_state[63:0], 64'h01010101_c6c6c6c6);
        tick();

        // Back-to-back: second accept coincides with the first handshake.
        s1 = {$urandom, $urandom, $urandom, $urandom};
        s2 = {$urandom, $urandom, $urandom, $urandom};
        send_accept(s1);
        in_valid = 1'b1;
        in_state = s2;
        wait_done(lat);
        check("b2b_latency1", lat, 4);
        check("b2b_out1", out_state, mix_state(s1));
        check("b2b_in_ready", {127'b0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        check("b2b_second_busy",  {127'b0, busy},      128'd1);
        check("b2b_second_valid", {127'b0, out_valid}, 128'd0);
        wait_done(lat);
        check("b2b_latency2", lat, 4);
        check("b2b_out2", out_state, mix_state(s2));
        tick();

        // Reset with col_idx at 2.
        send_accept({$urandom, $urandom, $urandom, $urandom});
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_out_valid", {127'b0, out_valid}, 128'd0);
        check("midrst_busy",      {127'b0, busy},      128'd0);
        check("midrst_out_state", out_state,           128'd0);
        tick();
        check("midrst_in_ready", {127'b0, in_ready}, 128'd1);
        send_accept({32'hdb135345, 96'h0});
        wait_done(lat);
        check("db13_latency", lat, 4);
        check("db13_out", out_state, {32'h8e4da1bc, 96'h0});
        tick();

        // Random states with random downstream stalls.
        for (int n = 0; n < 16; n++) begin
            s1 = {$urandom, $urandom, $urandom, $urandom};
            exp = mix_state(s1);
            out_ready = 1'b0;
            send_accept(s1);
            wait_done(lat);
            check("rnd_latency", lat, 4);
            check("rnd_out", out_state, exp);
            held = out_state;
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                check("rnd_hold", out_state, exp);
            end
            out_ready = 1'b1;
            tick();
            check("rnd_consumed", {127'b0, out_valid}, 128'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
